subline_req_splitter: RTL and testbench
=======================================

SUBLINE_REQ_SPLITTER -- requirements
Module: subline_req_splitter

Interface
REQ-001 Parameter: LINE_BYTES, default 64, cache-line size in bytes; fixed power of two, offset field = addr[5:0].
REQ-002 Parameter: CNT_W, default 32, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  scaled-address request present.
REQ-006 in_ready  output  1  splitter can accept a request this cycle.
REQ-007 in_scaled_addr  input  64  byte address of the sub-cache-line access (scaled address).
REQ-008 in_sub_size  input  6  sub-cache-line access size in bytes; 0 = null access.
REQ-009 req_valid  output  1  line request present.
REQ-010 req_ready  input  1  downstream accepts the line request.
REQ-011 req_line_addr  output  64  line-aligned address, bits [5:0] always 0.
REQ-012 req_byte_mask  output  64  bit k set = byte k of the line is accessed.
REQ-013 req_last  output  1  final line request belonging to the current input request.
REQ-014 stat_split_cnt  output  CNT_W  number of accepted requests that crossed a line boundary.
REQ-015 stat_null_cnt  output  CNT_W  number of accepted null (size 0) requests.

Function
REQ-016 Input handshake SHALL complete when in_valid & in_ready are both high on a rising clk edge.
REQ-017 in_ready SHALL be high only in state IDLE.
REQ-018 States SHALL be IDLE, FIRST and SECOND; transitions happen only on clk edges.
REQ-019 On acceptance, the block SHALL register off = addr[5:0], end = off + size - 1 (7-bit), base = {addr[63:6], 6'b0}, and size.
REQ-020 Null request (size 0): accepted, no line request issued, stat_null_cnt += 1, state remains IDLE.
REQ-021 Non-null request: IDLE -> FIRST; req_valid SHALL assert the cycle after acceptance (latency 1), never combinationally from in_valid.
REQ-022 FIRST, end < 64: line = base, mask bits off..end set, req_last = 1; on req_ready -> IDLE.
REQ-023 FIRST, end >= 64 (crossing): line = base, mask bits off..63, req_last = 0; on req_ready -> SECOND.
REQ-024 SECOND: line = base + 64 (mod 2^64), mask bits 0..(end-64), req_last = 1; on req_ready -> IDLE.
REQ-025 Line address wrap: base 0xFFFF_FFFF_FFFF_FFC0 crossing SHALL give second line 0x0, no error flagged.
REQ-026 While req_valid & !req_ready, req_line_addr, req_byte_mask and req_last SHALL hold stable; req_valid SHALL not drop.
REQ-027 Back-to-back: a request completing with req_last in cycle N returns to IDLE; in_ready high in cycle N+1 (one bubble per input request); sustained throughput 1 request per 2 cycles non-crossing, per 3 cycles crossing.
REQ-028 stat_split_cnt SHALL increment at acceptance of a crossing request; both counters saturate at all-ones.
REQ-029 popcount(mask FIRST) + popcount(mask SECOND, if issued) SHALL equal in_sub_size for every accepted request.
REQ-030 in_scaled_addr and in_sub_size are sampled only at acceptance; later input changes SHALL not affect in-flight requests.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, req_valid 0, req_last 0, req_line_addr 0, req_byte_mask 0, both counters 0.
REQ-032 in_ready SHALL be 0 while rst_n is low and SHALL go 1 on the first clk edge after release.
REQ-033 Reset mid-operation (FIRST or SECOND) SHALL discard the request; no remaining line request is issued after release.

Verification
REQ-034 addr 0x1000_0008, size 48, req_ready=1 -> one request next cycle: line 0x1000_0000, mask bits 8..55, last=1; stat_split_cnt 0.
REQ-035 addr 0x1000_0030, size 56 -> line 0x1000_0000 mask bits 48..63 last=0, then line 0x1000_0040 mask bits 0..39 last=1; stat_split_cnt 1.
REQ-036 addr 0xFFFF_FFFF_FFFF_FFF8, size 40 -> line 0xFFFF_FFFF_FFFF_FFC0 mask 56..63, then line 0x0 mask 0..31.
REQ-037 req_ready held low 5 cycles during FIRST of a crossing request -> outputs stable, in_ready 0, SECOND issued only after acceptance.
REQ-038 size 0 -> no req_valid, stat_null_cnt 1, in_ready stays high next cycle.
REQ-039 rst_n pulsed low while in SECOND -> req_valid 0 immediately, counters 0, no request after release; new request then processed normally.

Source files
------------

// File: rtl/subline_req_splitter_if.sv
// subline_req_splitter_if: request-in and line-request-out handshake bundle
interface subline_req_splitter_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_scaled_addr;
  logic [5:0]  in_sub_size;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_line_addr;
  logic [63:0] req_byte_mask;
  logic        req_last;
  modport master (
    output in_valid, in_scaled_addr, in_sub_size, req_ready,
    input  in_ready, req_valid, req_line_addr, req_byte_mask, req_last
  );
  modport slave (
    input  in_valid, in_scaled_addr, in_sub_size, req_ready,
    output in_ready, req_valid, req_line_addr, req_byte_mask, req_last
  );
endinterface

// File: rtl/subline_req_splitter.sv
// subline_req_splitter: turns a sub-line access into one or two masked line requests
module subline_req_splitter #(
  parameter int LINE_BYTES = 64,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  subline_req_splitter_if.slave bus,
  output logic [CNT_W-1:0]      stat_split_cnt,
  output logic [CNT_W-1:0]      stat_null_cnt
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;

  logic [1:0]  state;
  logic        alive;
  logic [63:0] base;
  logic [6:0]  endPos;
  logic        reqValid;
  logic        reqLast;
  logic [63:0] lineAddr;
  logic [63:0] byteMask;
  logic        accept;
  logic        isNull;
  logic [6:0]  acceptEnd;

  function automatic logic [63:0] rangeMask(input logic [5:0] lo, input logic [5:0] hi);
    return ({64{1'b1}} << lo) & ({64{1'b1}} >> (6'd63 - hi));
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // alive keeps in_ready low until the first edge after reset release
  assign bus.in_ready      = alive && state == IDLE;
  assign accept            = bus.in_valid && bus.in_ready;
  assign isNull            = bus.in_sub_size == 6'd0;
  assign acceptEnd         = {1'b0, bus.in_scaled_addr[5:0]} + {1'b0, bus.in_sub_size} - 7'd1;
  assign bus.req_valid     = reqValid;
  assign bus.req_last      = reqLast;
  assign bus.req_line_addr = lineAddr;
  assign bus.req_byte_mask = byteMask;

  // request FSM: load first line on acceptance, advance to second line on a crossing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      alive    <= 1'b0;
      base     <= '0;
      endPos   <= '0;
      reqValid <= 1'b0;
      reqLast  <= 1'b0;
      lineAddr <= '0;
      byteMask <= '0;
    end else begin
      alive <= 1'b1;
      if (accept && !isNull) begin
        state    <= FIRST;
        base     <= {bus.in_scaled_addr[63:6], 6'b0};
        endPos   <= acceptEnd;
        reqValid <= 1'b1;
        reqLast  <= !acceptEnd[6];
        lineAddr <= {bus.in_scaled_addr[63:6], 6'b0};
        byteMask <= rangeMask(bus.in_scaled_addr[5:0], acceptEnd[6] ? 6'd63 : acceptEnd[5:0]);
      end else if (state == FIRST && bus.req_ready && endPos[6]) begin
        state    <= SECOND;
        reqLast  <= 1'b1;
        lineAddr <= base + 64'(LINE_BYTES);
        byteMask <= rangeMask(6'd0, endPos[5:0]);
      end else if (state != IDLE && bus.req_ready) begin
        state    <= IDLE;
        reqValid <= 1'b0;
        reqLast  <= 1'b0;
      end
    end
  end

  // saturating statistics, counted at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_split_cnt <= '0;
      stat_null_cnt  <= '0;
    end else if (accept) begin
      stat_null_cnt  <= isNull ? satInc(stat_null_cnt) : stat_null_cnt;
      stat_split_cnt <= (!isNull && acceptEnd[6]) ? satInc(stat_split_cnt) : stat_split_cnt;
    end
  end
endmodule

// File: tb/tb_subline_req_splitter.sv
// tb_subline_req_splitter: directed stimulus with a queue scoreboard and handshake monitor
module tb_subline_req_splitter;
  typedef struct packed {
    logic [63:0] line;
    logic [63:0] mask;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] stat_split_cnt;
  logic [31:0] stat_null_cnt;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t e;

  subline_req_splitter_if bus ();

  subline_req_splitter #(.LINE_BYTES(64), .CNT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .stat_split_cnt(stat_split_cnt),
    .stat_null_cnt(stat_null_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every accepted line request is popped and compared
  always @(negedge clk) begin
    if (rst_n && bus.req_valid && bus.req_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_req: got line %h mask %h last %b, expected none",
                 bus.req_line_addr, bus.req_byte_mask, bus.req_last);
      end else begin
        e = q.pop_front();
        if (bus.req_line_addr !== e.line || bus.req_byte_mask !== e.mask || bus.req_last !== e.last) begin
          fails++;
          $display("FAIL line_req: got line %h mask %h last %b, expected line %h mask %h last %b",
                   bus.req_line_addr, bus.req_byte_mask, bus.req_last, e.line, e.mask, e.last);
        end
      end
    end
  end

  task automatic expect_req(input logic [63:0] line, input logic [63:0] mask, input logic last);
    q.push_back('{line: line, mask: mask, last: last});
  endtask

  task automatic send(input logic [63:0] a, input logic [5:0] s);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0, expected 1");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_scaled_addr = a;
    bus.in_sub_size = s;
    #1 check("no_comb_valid", bus.req_valid, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_scaled_addr = 64'hDEAD_BEEF_CAFE_F00D;
    bus.in_sub_size = 6'd33;
    check("valid_latency1", bus.req_valid, s != 6'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.req_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", q.size() == 0 && !bus.req_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_scaled_addr = '0;
    bus.in_sub_size = '0;
    bus.req_ready = 1'b1;
    #3;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_req_valid", bus.req_valid, 0);
    check("rst_line", bus.req_line_addr, 0);
    check("rst_mask", bus.req_byte_mask, 0);
    check("rst_last", bus.req_last, 0);
    check("rst_split", stat_split_cnt, 0);
    check("rst_null", stat_null_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1 check("in_ready_after_edge", bus.in_ready, 1);

    expect_req(64'h1000_0000, 64'h00FF_FFFF_FFFF_FF00, 1'b1);
    send(64'h1000_0008, 6'd48);
    @(posedge clk);
    #1 check("in_ready_after_last", bus.in_ready, 1);
    drain();
    check("split_after_single", stat_split_cnt, 0);

    expect_req(64'h1000_0000, 64'hFFFF_0000_0000_0000, 1'b0);
    expect_req(64'h1000_0040, 64'h0000_00FF_FFFF_FFFF, 1'b1);
    send(64'h1000_0030, 6'd56);
    drain();
    check("split_after_cross", stat_split_cnt, 1);

    expect_req(64'hFFFF_FFFF_FFFF_FFC0, 64'hFF00_0000_0000_0000, 1'b0);
    expect_req(64'h0000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFF8, 6'd40);
    drain();
    check("split_after_wrap", stat_split_cnt, 2);

    expect_req(64'h40, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    send(64'h40, 6'd63);
    expect_req(64'h40, 64'h8000_0000_0000_0000, 1'b1);
    send(64'h7F, 6'd1);
    expect_req(64'h80, 64'h8000_0000_0000_0000, 1'b0);
    expect_req(64'hC0, 64'h0000_0000_0000_0001, 1'b1);
    send(64'hBF, 6'd2);
    drain();
    check("split_after_edges", stat_split_cnt, 3);

    send(64'h123, 6'd0);
    check("null_cnt", stat_null_cnt, 1);
    check("null_in_ready", bus.in_ready, 1);
    check("null_split", stat_split_cnt, 3);

    bus.req_ready = 1'b0;
    expect_req(64'h2000_0000, 64'hFF00_0000_0000_0000, 1'b0);
    expect_req(64'h2000_0040, 64'h0000_0000_0000_00FF, 1'b1);
    send(64'h2000_0038, 6'd16);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", bus.req_valid, 1);
      check("stall_line", bus.req_line_addr, 64'h2000_0000);
      check("stall_mask", bus.req_byte_mask, 64'hFF00_0000_0000_0000);
      check("stall_last", bus.req_last, 0);
      check("stall_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.req_ready = 1'b1;
    drain();
    check("split_after_stall", stat_split_cnt, 4);

    bus.req_ready = 1'b0;
    expect_req(64'h3000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0);
    send(64'h3000_0020, 6'd48);
    bus.req_ready = 1'b1;
    @(posedge clk);
    #1 bus.req_ready = 1'b0;
    check("second_valid", bus.req_valid, 1);
    check("second_line", bus.req_line_addr, 64'h3000_0040);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.req_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_split", stat_split_cnt, 0);
    check("midrst_null", stat_null_cnt, 0);
    check("midrst_mask", bus.req_byte_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("post_rst_idle", bus.req_valid, 0);
    expect_req(64'h40, 64'h0000_0000_0000_00FF, 1'b1);
    send(64'h40, 6'd8);
    drain();
    check("post_rst_split", stat_split_cnt, 0);
    check("post_rst_null", stat_null_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
